// File: rtl/volume.sv
// Mono PCM attenuator: registered right-shift level stepped by level-sensitive up/down controls.
// Zero-cycle sample path (sound_o is combinational), level changes one step per clock, no backpressure.
module volume #(
    parameter int width_p         = 24,
    parameter int max_shift_p     = 7,
    parameter int min_dec_shift_p = 1,
    parameter int level_width_p   = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [width_p-1:0] sound_i,
    input  logic               up_i,
    input  logic               down_i,
    output logic [width_p-1:0] sound_o
);

    localparam logic [level_width_p-1:0] level_max_lp = level_width_p'(max_shift_p);
    localparam logic [level_width_p-1:0] level_min_lp = level_width_p'(min_dec_shift_p);
    localparam logic [level_width_p-1:0] level_one_lp = level_width_p'(1);

    logic [level_width_p-1:0] level_q;
    logic [level_width_p-1:0] level_d;

    always_comb begin
        level_d = level_q;
        case ({up_i, down_i})
            2'b10: begin
                if (level_q < level_max_lp) begin
                    level_d = level_q + level_one_lp;
                end
            end
            // Decrements stop above the floor, so level 0 is only reachable through reset.
            2'b01: begin
                if (level_q > level_min_lp) begin
                    level_d = level_q - level_one_lp;
                end
            end
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            level_q <= '0;
        end else begin
            level_q <= level_d;
        end
    end

    assign sound_o = sound_i >> level_q;

endmodule

// File: tb/tb_volume.sv
// Directed bench for volume: driver queues expected samples, monitor compares on each sample strobe.
module tb_volume;

    logic        clk_i;
    logic        reset_i;
    logic [23:0] sound_i;
    logic        up_i;
    logic        down_i;
    logic [23:0] sound_o;

    typedef struct {
        string       name;
        logic [23:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    event sample_ev;

    volume #(
        .width_p(24),
        .max_shift_p(7),
        .min_dec_shift_p(1),
        .level_width_p(8)
    ) dut (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .sound_i(sound_i),
        .up_i   (up_i),
        .down_i (down_i),
        .sound_o(sound_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Monitor: every strobe means the DUT output is presented and settled.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_sample actual=%06h required=none", sound_o);
            end else begin
                e = exp_q.pop_front();
                if (sound_o !== e.exp) begin
                    errors++;
                    $display("FAIL %s actual=%06h required=%06h", e.name, sound_o, e.exp);
                end
            end
        end
    end

    task automatic expect_now(input string name, input logic [23:0] exp);
        exp_q.push_back('{name, exp});
        -> sample_ev;
        #1;
    endtask

    task automatic cycle(input logic u, input logic d, input logic [23:0] s,
                         input logic [23:0] exp, input string name);
        up_i    = u;
        down_i  = d;
        sound_i = s;
        @(posedge clk_i);
        #2;
        expect_now(name, exp);
    endtask

    task automatic do_reset();
        up_i    = 1'b0;
        down_i  = 1'b0;
        reset_i = 1'b1;
        @(posedge clk_i);
        #3;
        reset_i = 1'b0;
    endtask

    // Mixed sequence: {up,down} per cycle with sound_i = index; expected = index >> level after edge.
    logic [1:0]  mix_ctl [11] = '{2'b10, 2'b10, 2'b10, 2'b01, 2'b11, 2'b01,
                                  2'b01, 2'b01, 2'b10, 2'b10, 2'b01};
    logic [23:0] mix_exp [11] = '{24'd0, 24'd0, 24'd0, 24'd0, 24'd1, 24'd2,
                                  24'd3, 24'd3, 24'd2, 24'd1, 24'd2};
    logic [23:0] sat_exp [10] = '{24'h400000, 24'h200000, 24'h100000, 24'h080000, 24'h040000,
                                  24'h020000, 24'h010000, 24'h010000, 24'h010000, 24'h010000};

    initial begin
        reset_i = 1'b1;
        up_i    = 1'b0;
        down_i  = 1'b0;
        sound_i = 24'h00000A;
        #3;
        expect_now("reset_pass", 24'h00000A);
        // up requests under reset must not move the level
        up_i    = 1'b1;
        sound_i = 24'hFFFFFF;
        @(posedge clk_i);
        @(posedge clk_i);
        #2;
        expect_now("reset_holds_level", 24'hFFFFFF);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Increment
        cycle(1'b1, 1'b0, 24'd0, 24'h000000, "inc_l1");
        cycle(1'b1, 1'b0, 24'd1, 24'h000000, "inc_l2");
        cycle(1'b1, 1'b0, 24'd2, 24'h000000, "inc_l3");
        cycle(1'b0, 1'b0, 24'hFFFFFF, 24'h1FFFFF, "inc_probe_l3");

        // Asynchronous reset mid-cycle at level 3
        sound_i = 24'h123456;
        #1;
        expect_now("pre_async_l3", 24'h02468A);
        reset_i = 1'b1;
        #1;
        expect_now("async_reset_immediate", 24'h123456);
        @(negedge clk_i);
        reset_i = 1'b0;

        // Mixed sequence
        do_reset();
        for (int i = 0; i < 11; i++) begin
            cycle(mix_ctl[i][1], mix_ctl[i][0], 24'(i), mix_exp[i], $sformatf("mix_%0d", i));
        end
        cycle(1'b0, 1'b0, 24'hFFFFFF, 24'h3FFFFF, "mix_probe_l2");

        // Saturation high
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 1'b0, 24'h800000, sat_exp[i], $sformatf("sat_%0d", i));
        end
        cycle(1'b0, 1'b0, 24'hFFFFFF, 24'h01FFFF, "sat_probe_l7");

        // Floor at 1
        do_reset();
        cycle(1'b1, 1'b0, 24'h000003, 24'h000001, "floor_up1");
        cycle(1'b1, 1'b0, 24'h000003, 24'h000000, "floor_up2");
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b1, 24'h000003, 24'h000001, $sformatf("floor_down_%0d", i));
        end
        cycle(1'b0, 1'b0, 24'hFFFFFF, 24'h7FFFFF, "floor_probe_l1");

        // Down from level 0 stays at 0
        do_reset();
        cycle(1'b0, 1'b1, 24'h00000A, 24'h00000A, "zero_down_0");
        cycle(1'b0, 1'b1, 24'hFFFFFF, 24'hFFFFFF, "zero_down_1");

        // Combinational path at level 2
        do_reset();
        cycle(1'b1, 1'b0, 24'h000010, 24'h000008, "comb_up1");
        cycle(1'b1, 1'b0, 24'h000010, 24'h000004, "comb_l2_a");
        up_i    = 1'b0;
        sound_i = 24'h000040;
        #1;
        expect_now("comb_l2_midcycle", 24'h000010);

        #5;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
